// File: rtl/pool2_cu_if.sv
// rtl/pool2_cu_if.sv - handshake and buffer-port bundle between pool2_cu and its neighbours
interface pool2_cu_if #(
    parameter int AW  = 7,
    parameter int NAW = 5
);
    logic           start_from_previous;
    logic           end_to_previous;
    logic           end_from_next;
    logic           start_to_next;
    logic           ifm_sel_previous;
    logic [1:0]     ifm_sel_next;
    logic           ifm_enable_read_current;
    logic [AW-1:0]  ifm_address_read_current;
    logic           pool_first;
    logic           pool_enable;
    logic           ifm_enable_write_next;
    logic [NAW-1:0] ifm_address_write_next;
    logic           pool_avg;

    modport master (
        input  start_from_previous, end_from_next,
        output end_to_previous, start_to_next, ifm_sel_previous, ifm_sel_next,
               ifm_enable_read_current, ifm_address_read_current, pool_first,
               pool_enable, ifm_enable_write_next, ifm_address_write_next, pool_avg
    );

    modport slave (
        output start_from_previous, end_from_next,
        input  end_to_previous, start_to_next, ifm_sel_previous, ifm_sel_next,
               ifm_enable_read_current, ifm_address_read_current, pool_first,
               pool_enable, ifm_enable_write_next, ifm_address_write_next, pool_avg
    );
endinterface

// File: rtl/pool2_cu.sv
// rtl/pool2_cu.sv - 2x2 stride-2 pooling control unit; POOL_AVG_EN selects average pooling
module pool2_cu #(
    parameter int IFM_SIZE        = 10,
    parameter int IFM_DEPTH       = 16,
    parameter int NUMBER_OF_UNITS = 6,
    parameter int PIPE_DELAY      = 2
) (
    input  logic      clk,
    input  logic      reset,
    pool2_cu_if.master bus
);
    localparam int NUMBER_OF_GROUPS      = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
    localparam int IFM_SIZE_NEXT         = IFM_SIZE / 2;
    localparam int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE);
    localparam int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT);
    localparam int CW = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
    localparam int DW = $clog2(PIPE_DELAY + 1);
    localparam int AW = ADDRESS_SIZE_IFM;
    localparam int NAW = ADDRESS_SIZE_NEXT_IFM;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_NEXT} state_t;

    state_t                state, state_next;
    logic [1:0]            pos;
    logic [CW-1:0]         col, row;
    logic [DW-1:0]         drain_cnt;
    logic [NAW-1:0]        write_address;
    logic [1:0]            sel_next;
    logic                  sel_previous;
    logic                  pool_enable_q, pool_first_q;
    logic [PIPE_DELAY-1:0] write_pipe;
    logic                  read_strobe, end_prev, start_next, advance, last_read;
    logic [AW-1:0]         offset;

    assign last_read = (pos == 2'd3) && (col == CW'(IFM_SIZE_NEXT - 1)) &&
                       (row == CW'(IFM_SIZE_NEXT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        end_prev    = 1'b0;
        read_strobe = 1'b0;
        start_next  = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                end_prev = 1'b1;
                if (bus.start_from_previous) state_next = READ;
            end
            READ: begin
                read_strobe = 1'b1;
                if (last_read) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DW'(PIPE_DELAY - 1)) state_next = WAIT_NEXT;
            end
            default: begin
                if (bus.end_from_next) begin
                    start_next = 1'b1;
                    advance    = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Window walk: pos sweeps the 2x2 window, then col, then row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= '0;
            col <= '0;
            row <= '0;
        end else if (read_strobe) begin
            pos <= pos + 2'd1;
            if (pos == 2'd3) begin
                if (col == CW'(IFM_SIZE_NEXT - 1)) begin
                    col <= '0;
                    row <= (row == CW'(IFM_SIZE_NEXT - 1)) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end else if (state == IDLE) begin
            pos <= '0;
            col <= '0;
            row <= '0;
        end
    end

    always_comb begin
        case (pos)
            2'd0:    offset = '0;
            2'd1:    offset = AW'(1);
            2'd2:    offset = AW'(IFM_SIZE);
            default: offset = AW'(IFM_SIZE + 1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt     <= '0;
            write_address <= '0;
            sel_next      <= '0;
            sel_previous  <= 1'b0;
            pool_enable_q <= 1'b0;
            pool_first_q  <= 1'b0;
            write_pipe    <= '0;
        end else begin
            drain_cnt     <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            pool_enable_q <= read_strobe;
            pool_first_q  <= read_strobe && (pos == 2'd0);
            write_pipe[0] <= read_strobe && (pos == 2'd3);
            for (int i = 1; i < PIPE_DELAY; i++) write_pipe[i] <= write_pipe[i-1];
            if (state == IDLE)
                write_address <= '0;
            else if (write_pipe[PIPE_DELAY-1])
                write_address <= (write_address == NAW'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1)) ?
                                 '0 : write_address + NAW'(1);
            if (advance) begin
                sel_next     <= (sel_next == 2'(NUMBER_OF_GROUPS - 1)) ? 2'd0 : sel_next + 2'd1;
                sel_previous <= ~sel_previous;
            end
        end
    end

    assign bus.end_to_previous          = end_prev;
    assign bus.start_to_next            = start_next;
    assign bus.ifm_sel_previous         = sel_previous;
    assign bus.ifm_sel_next             = sel_next;
    assign bus.ifm_enable_read_current  = read_strobe;
    assign bus.ifm_address_read_current = AW'(row) * AW'(2 * IFM_SIZE) + (AW'(col) << 1) + offset;
    assign bus.pool_first               = pool_first_q;
    assign bus.pool_enable              = pool_enable_q;
    assign bus.ifm_enable_write_next    = write_pipe[PIPE_DELAY-1];
    assign bus.ifm_address_write_next   = write_address;
`ifdef POOL_AVG_EN
    assign bus.pool_avg = write_pipe[PIPE_DELAY-1];
`else
    assign bus.pool_avg = 1'b0;
`endif
endmodule

// File: tb/tb_pool2_cu.sv
// tb/tb_pool2_cu.sv - directed self-checking bench for pool2_cu
module tb_pool2_cu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pool2_cu_if #(.AW(7), .NAW(5)) bus ();

    pool2_cu #(.IFM_SIZE(10), .IFM_DEPTH(16), .NUMBER_OF_UNITS(6), .PIPE_DELAY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic       rd_en_a  [0:199];
    logic [6:0] rd_addr_a[0:199];
    logic       wr_en_a  [0:199];
    logic [4:0] wr_addr_a[0:199];
    logic       first_a  [0:199];
    logic       pen_a    [0:199];
    logic       stn_a    [0:199];
    logic       etp_a    [0:199];
    logic       avg_a    [0:199];
    logic [1:0] seln_a   [0:199];
    logic       selp_a   [0:199];

    task automatic apply_reset();
        bus.start_from_previous = 1'b0;
        bus.end_from_next       = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Cycle 0 carries the start pulse; cycles 1..ncyc are recorded at the falling edge.
    task automatic capture(input int ncyc, input int rel, input int pa, input int pb);
        for (int k = 0; k < 200; k++) begin
            rd_en_a[k] = 1'b0; rd_addr_a[k] = '0; wr_en_a[k] = 1'b0; wr_addr_a[k] = '0;
            first_a[k] = 1'b0; pen_a[k] = 1'b0; stn_a[k] = 1'b0; etp_a[k] = 1'b0;
            avg_a[k] = 1'b0; seln_a[k] = '0; selp_a[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.start_from_previous = 1'b1;
        bus.end_from_next       = (rel == 0);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            bus.start_from_previous = (k == pa) || (k == pb);
            bus.end_from_next       = (k >= rel);
            @(negedge clk);
            rd_en_a[k]   = bus.ifm_enable_read_current;
            rd_addr_a[k] = bus.ifm_address_read_current;
            wr_en_a[k]   = bus.ifm_enable_write_next;
            wr_addr_a[k] = bus.ifm_address_write_next;
            first_a[k]   = bus.pool_first;
            pen_a[k]     = bus.pool_enable;
            stn_a[k]     = bus.start_to_next;
            etp_a[k]     = bus.end_to_previous;
            avg_a[k]     = bus.pool_avg;
            seln_a[k]    = bus.ifm_sel_next;
            selp_a[k]    = bus.ifm_sel_previous;
        end
        bus.start_from_previous = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] others;
        bus.start_from_previous = 1'b0;
        bus.end_from_next       = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.end_to_previous !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_etp_in_reset: got %b expected 1", bus.end_to_previous);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            others = {bus.start_to_next, bus.ifm_sel_previous, bus.ifm_sel_next,
                      bus.ifm_enable_read_current, bus.ifm_address_read_current, bus.pool_first,
                      bus.pool_enable, bus.ifm_enable_write_next, bus.ifm_address_write_next,
                      bus.pool_avg};
            n_tests++;
            if (bus.end_to_previous !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_etp cycle %0d: got %b expected 1", k, bus.end_to_previous);
            end
            n_tests++;
            if (others !== 24'd0) begin
                n_fail++;
                $display("FAIL idle_outputs cycle %0d: got %h expected 0", k, others);
            end
        end
    endtask

    task automatic test_single_run();
        int spot_cyc [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 21, 22, 23, 24, 97, 98, 99, 100};
        int spot_addr[16] = '{0, 1, 10, 11, 2, 3, 12, 13, 20, 21, 30, 31, 88, 89, 98, 99};
        int reads = 0, writes = 0;
        int bad_rd = 0, bad_wr = 0, bad_waddr = 0, bad_first = 0, bad_pen = 0;
        int bad_stn = 0, bad_etp = 0, bad_avg = 0;
        logic exp_wr, exp_avg;
        apply_reset();
        capture(110, 0, 0, 0);
        for (int k = 1; k <= 110; k++) begin
            exp_wr = (k >= 6) && (k <= 102) && ((k - 6) % 4 == 0);
`ifdef POOL_AVG_EN
            exp_avg = exp_wr;
`else
            exp_avg = 1'b0;
`endif
            if (rd_en_a[k] === 1'b1) reads++;
            if (rd_en_a[k] !== ((k >= 1) && (k <= 100))) bad_rd++;
            if (wr_en_a[k] !== exp_wr) bad_wr++;
            if (exp_wr) begin
                if (wr_addr_a[k] !== 5'((k - 6) / 4)) bad_waddr++;
            end
            if (wr_en_a[k] === 1'b1) writes++;
            if (first_a[k] !== ((k >= 2) && (k <= 98) && ((k - 2) % 4 == 0))) bad_first++;
            if (pen_a[k] !== ((k >= 2) && (k <= 101))) bad_pen++;
            if (stn_a[k] !== (k == 103)) bad_stn++;
            if (etp_a[k] !== (k >= 104)) bad_etp++;
            if (avg_a[k] !== exp_avg) bad_avg++;
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (rd_addr_a[spot_cyc[i]] !== 7'(spot_addr[i])) begin
                n_fail++;
                $display("FAIL read_addr cycle %0d: got %0d expected %0d",
                         spot_cyc[i], rd_addr_a[spot_cyc[i]], spot_addr[i]);
            end
        end
        n_tests++;
        if (reads != 100) begin n_fail++; $display("FAIL read_count: got %0d expected 100", reads); end
        n_tests++;
        if (bad_rd != 0) begin n_fail++; $display("FAIL read_window: got %0d bad cycles expected 0", bad_rd); end
        n_tests++;
        if (writes != 25) begin n_fail++; $display("FAIL write_count: got %0d expected 25", writes); end
        n_tests++;
        if (bad_wr != 0) begin n_fail++; $display("FAIL write_timing: got %0d bad cycles expected 0", bad_wr); end
        n_tests++;
        if (bad_waddr != 0) begin n_fail++; $display("FAIL write_addr: got %0d bad writes expected 0", bad_waddr); end
        n_tests++;
        if (wr_addr_a[102] !== 5'd24) begin n_fail++; $display("FAIL last_write_addr: got %0d expected 24", wr_addr_a[102]); end
        n_tests++;
        if (bad_first != 0) begin n_fail++; $display("FAIL pool_first: got %0d bad cycles expected 0", bad_first); end
        n_tests++;
        if (bad_pen != 0) begin n_fail++; $display("FAIL pool_enable: got %0d bad cycles expected 0", bad_pen); end
        n_tests++;
        if (bad_stn != 0) begin n_fail++; $display("FAIL start_to_next: got %0d bad cycles expected 0", bad_stn); end
        n_tests++;
        if (bad_etp != 0) begin n_fail++; $display("FAIL end_to_previous: got %0d bad cycles expected 0", bad_etp); end
        n_tests++;
        if (bad_avg != 0) begin n_fail++; $display("FAIL pool_avg: got %0d bad cycles expected 0", bad_avg); end
        n_tests++;
        if (seln_a[110] !== 2'd1 || selp_a[110] !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_after_run: got next=%0d prev=%0d expected next=1 prev=1", seln_a[110], selp_a[110]);
        end
    endtask

    task automatic test_wait_next();
        int pulses = 0, reads = 0;
        apply_reset();
        capture(160, 153, 0, 0);
        for (int k = 1; k <= 160; k++) begin
            if (stn_a[k] === 1'b1) pulses++;
            if (rd_en_a[k] === 1'b1) reads++;
        end
        n_tests++;
        if (pulses != 1 || stn_a[153] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_pulse: got %0d pulses, at153=%b expected 1 pulse at 153", pulses, stn_a[153]);
        end
        n_tests++;
        if (etp_a[152] !== 1'b0 || etp_a[154] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_etp: got c152=%b c154=%b expected 0 and 1", etp_a[152], etp_a[154]);
        end
        n_tests++;
        if (seln_a[152] !== 2'd0 || seln_a[160] !== 2'd1) begin
            n_fail++;
            $display("FAIL wait_sel_next: got %0d->%0d expected 0->1", seln_a[152], seln_a[160]);
        end
        n_tests++;
        if (selp_a[152] !== 1'b0 || selp_a[160] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_sel_prev: got %0d->%0d expected 0->1", selp_a[152], selp_a[160]);
        end
        n_tests++;
        if (reads != 100) begin n_fail++; $display("FAIL wait_reads: got %0d expected 100", reads); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_next[3] = '{2'd1, 2'd2, 2'd0};
        logic       exp_prev[3] = '{1'b1, 1'b0, 1'b1};
        int reads;
        apply_reset();
        for (int g = 0; g < 3; g++) begin
            reads = 0;
            capture(105, 0, 10 + 20 * g, 101);
            for (int k = 1; k <= 105; k++) if (rd_en_a[k] === 1'b1) reads++;
            n_tests++;
            if (reads != 100) begin
                n_fail++;
                $display("FAIL b2b_reads group %0d: got %0d expected 100", g, reads);
            end
            n_tests++;
            if (seln_a[105] !== exp_next[g] || selp_a[105] !== exp_prev[g]) begin
                n_fail++;
                $display("FAIL b2b_sel group %0d: got next=%0d prev=%0d expected next=%0d prev=%0d",
                         g, seln_a[105], selp_a[105], exp_next[g], exp_prev[g]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        apply_reset();
        @(posedge clk);
        #1 bus.start_from_previous = 1'b1;
        @(posedge clk);
        #1 bus.start_from_previous = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        n_tests++;
        if (bus.ifm_enable_read_current !== 1'b1 || bus.ifm_address_read_current !== 7'd39) begin
            n_fail++;
            $display("FAIL mid_read40: got en=%b addr=%0d expected en=1 addr=39",
                     bus.ifm_enable_read_current, bus.ifm_address_read_current);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.end_to_previous !== 1'b1 || bus.ifm_enable_read_current !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got etp=%b rd=%b expected etp=1 rd=0",
                     bus.end_to_previous, bus.ifm_enable_read_current);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.ifm_enable_write_next !== 1'b0 || bus.pool_avg !== 1'b0) writes++;
        end
        n_tests++;
        if (writes != 0) begin n_fail++; $display("FAIL mid_no_write: got %0d write cycles expected 0", writes); end
        capture(4, 0, 0, 0);
        n_tests++;
        if (rd_en_a[1] !== 1'b1 || rd_addr_a[1] !== 7'd0 || rd_addr_a[2] !== 7'd1) begin
            n_fail++;
            $display("FAIL mid_restart: got en=%b a1=%0d a2=%0d expected en=1 a1=0 a2=1",
                     rd_en_a[1], rd_addr_a[1], rd_addr_a[2]);
        end
    endtask

    initial begin
        bus.start_from_previous = 1'b0;
        bus.end_from_next       = 1'b0;
        test_reset();
        test_single_run();
        test_wait_next();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
